serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single 1-bit `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first, with a registered carry between bits. It provides a start/busy/done handshake so a host FSM can trade area for latency. It sits beside the ripple adders as the minimum-area addition path.

---
 rtl/serial_adder_ctrl_pkg.sv | 17 +
 rtl/serial_adder_ctrl_if.sv | 28 ++
 rtl/serial_adder_ctrl_full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl shared definitions
// FSM encodings, default width, counter sizing
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl host bundle
// start/operands in, busy/done/result out
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: one-bit datapath slice
// used once by the serial controller
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first
// one full_adder reused each cycle, carry kept in a flop
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s;
  logic             fa_c;

  // bit 0 of the result shifter falls off each shift
  wire unused_s0 = s_sr_q[0];

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // next state, shifter updates, result capture
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          s_sr_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // register everything; reset aborts and clears
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench
// directed 8-bit vectors plus a 4-bit exhaustive sweep
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [7:0] held8;
  logic [3:0] held4;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, got, exp);
    end
  endtask

  // 8-bit monitor: score done pulses, check sum holds
  always @(negedge clk) begin
    if (rst) begin
      held8 = '0;
    end else if (bus8.done) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 1, 0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("sum8", bus8.sum, e[7:0]);
        chk("cout8", bus8.cout, e[8]);
      end
      held8 = bus8.sum;
    end else begin
      chk("hold8", bus8.sum, held8);
    end
  end

  // 4-bit monitor: score done pulses, check sum holds
  always @(negedge clk) begin
    if (rst) begin
      held4 = '0;
    end else if (bus4.done) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 1, 0);
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        chk("sum4", bus4.sum, e[3:0]);
        chk("cout4", bus4.cout, e[4]);
      end
      held4 = bus4.sum;
    end else begin
      chk("hold4", bus4.sum, held4);
    end
  end

  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic ci,
                     input logic [7:0] es,
                     input logic ec,
                     input int chg_at);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = ci;
    q8.push_back({ec, es});
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_at = k;
        break;
      end
      if (k == chg_at) begin
        #1;
        bus8.a   = 8'hAA;
        bus8.b   = 8'h55;
        bus8.cin = 1'b1;
      end
    end
    chk("done8_at", done_at, 9);
    chk("busy8_cycles", busy_n, 9);
  endtask

  task automatic op4(input logic [3:0] a,
                     input logic [3:0] b,
                     input logic ci);
    logic [4:0] m;
    int done_at;
    done_at = 0;
    m = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    @(posedge clk); #1;
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = ci;
    q4.push_back(m);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus4.done) begin
        done_at = k;
        break;
      end
    end
    chk("done4_at", done_at, 5);
  endtask

  initial begin
    int nd;
    int dat[3];
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.cin   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy8", bus8.busy, 0);
    chk("rst_done8", bus8.done, 0);
    chk("rst_sum8", bus8.sum, 0);
    chk("rst_cout8", bus8.cout, 0);
    chk("rst_busy4", bus4.busy, 0);
    chk("rst_sum4", bus4.sum, 0);
    #1 rst = 1'b0;

    op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
    op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

    // start held high: one accept per WIDTH+2 cycles
    nd = 0;
    dat = '{0, 0, 0};
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.a     = 8'h12;
    bus8.b     = 8'h34;
    bus8.cin   = 1'b0;
    repeat (3) q8.push_back({1'b0, 8'h46});
    @(posedge clk);
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (nd < 3) dat[nd] = k;
        nd++;
      end
      if (k == 29) begin
        #1 bus8.start = 1'b0;
      end
    end
    chk("held_done_cnt", nd, 3);
    chk("held_done0", dat[0], 9);
    chk("held_done1", dat[1], 19);
    chk("held_done2", dat[2], 29);

    // reset during RUN cycle 4 aborts the add
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.a     = 8'h77;
    bus8.b     = 8'h11;
    bus8.cin   = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        #1 rst = 1'b1;
      end
      if (k == 5) begin
        chk("abort_busy", bus8.busy, 0);
        chk("abort_done", bus8.done, 0);
        chk("abort_sum", bus8.sum, 0);
        chk("abort_cout", bus8.cout, 0);
        #1 rst = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    chk("abort_idle", bus8.busy, 0);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          op4(4'(a), 4'(b), 1'(c));
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
